// File: rtl/rr_mux8_arbiter.sv
// Round-robin arbiter that shares one 8:1 mux output among 8 requesters,
// holding each grant for a burst of up to MAX_BURST valid/ready beats.
module rr_mux8_arbiter #(
    parameter int W         = 8,
    parameter int MAX_BURST = 4
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic [7:0]     req,
    input  logic [8*W-1:0] data_in,
    input  logic           out_ready,
    output logic [7:0]     grant,
    output logic [2:0]     sel,
    output logic           out_valid,
    output logic [W-1:0]   out_data,
    output logic           last
);

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    localparam logic [7:0] LAST_BEAT = 8'(MAX_BURST - 1);

    state_t     state_r;
    logic [7:0] grant_r;
    logic [2:0] sel_r;
    logic [2:0] ptr_r;
    logic [7:0] cnt_r;

    logic       valid_s;
    logic       fire_s;
    logic       at_last_s;
    logic [2:0] pick_s;

    // First requester at or after p, wrapping modulo 8; p itself when none.
    function automatic logic [2:0] rr_pick(input logic [7:0] r, input logic [2:0] p);
        logic [2:0] idx;
        logic [2:0] pick;
        logic       found;
        pick  = p;
        found = 1'b0;
        for (int k = 0; k < 8; k++) begin
            idx = p + 3'(k);
            if (!found && r[idx]) begin
                pick  = idx;
                found = 1'b1;
            end
        end
        return pick;
    endfunction

    // Beat qualification and the data path through the shared mux.
    always_comb begin
        valid_s   = (state_r == GRANT) && req[sel_r];
        fire_s    = valid_s && out_ready;
        at_last_s = (cnt_r == LAST_BEAT);
        pick_s    = rr_pick(req, ptr_r);
        if (valid_s) begin
            out_data = data_in[sel_r*W +: W];
        end else begin
            out_data = '0;
        end
    end

    assign out_valid = valid_s;
    assign last      = valid_s && at_last_s;
    assign grant     = grant_r;
    assign sel       = sel_r;

    // Arbitration / burst sequencer; a release always passes through IDLE once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
            grant_r <= 8'h00;
            sel_r   <= 3'd0;
            ptr_r   <= 3'd0;
            cnt_r   <= 8'd0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (|req) begin
                        sel_r   <= pick_s;
                        grant_r <= 8'd1 << pick_s;
                        cnt_r   <= 8'd0;
                        state_r <= GRANT;
                    end else begin
                        state_r <= IDLE;
                    end
                end
                GRANT: begin
                    // A dropped request ends the burst without moving a beat.
                    if (!req[sel_r] || (fire_s && at_last_s)) begin
                        state_r <= IDLE;
                        grant_r <= 8'h00;
                        cnt_r   <= 8'd0;
                        ptr_r   <= sel_r + 3'd1;
                    end else if (fire_s) begin
                        cnt_r <= cnt_r + 8'd1;
                    end else begin
                        cnt_r <= cnt_r;
                    end
                end
                default: begin
                    state_r <= IDLE;
                    grant_r <= 8'h00;
                    cnt_r   <= 8'd0;
                end
            endcase
        end
    end

endmodule
